// File: rtl/izhikevich_core_mux.sv
// Time-multiplexed Izhikevich neuron core: one forward-Euler timestep over all
// NUM_NEURONS neurons per start pulse, on a single shared Q-format datapath.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset (discards any partial timestep)
//   start   request one timestep over all neurons (honoured only in IDLE)
//   step    Euler step, latched on accepted start
//   i_flat  input currents, neuron k at [k*N +: N], sampled in neuron k's FETCH
//   busy    high while the timestep is in progress
//   done    one-cycle pulse when the timestep completes
//   spikes  bit k set when neuron k fired during the current/last timestep
//   rd_idx  readback select
//   v_out   combinational v[rd_idx] (0 when rd_idx is out of range)
//   w_out   combinational w[rd_idx] (0 when rd_idx is out of range)
module izhikevich_core_mux #(
    parameter int unsigned N           = 16,
    parameter int unsigned Q           = 8,
    parameter int unsigned NUM_NEURONS = 4,
    parameter logic [N-1:0] A          = 16'h0005,
    parameter logic [N-1:0] B          = 16'h0033,
    parameter logic [N-1:0] C          = 16'hFF5A,
    parameter logic [N-1:0] D          = 16'h0014,
    parameter logic [N-1:0] V_TH       = 16'h004C,
    parameter logic [N-1:0] V_INIT     = 16'hFF5A,
    parameter logic [N-1:0] W_INIT     = 16'hFFDF,
    localparam int unsigned IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N-1:0]             step,
    input  logic [NUM_NEURONS*N-1:0] i_flat,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_NEURONS-1:0]   spikes,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [N-1:0]             v_out,
    output logic [N-1:0]             w_out
);

    localparam int unsigned W2 = 2 * N;

    // Saturation bounds expressed at double width for clamping products/sums
    localparam logic signed [W2-1:0] SMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W2-1:0] SMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    // Polynomial constants in Q format; 1.4 rounded to nearest
    localparam logic signed [N-1:0] K_FOUR = N'(4 << Q);
    localparam logic signed [N-1:0] K_FIVE = N'(5 << Q);
    localparam logic signed [N-1:0] K_1P4  = N'((14 * (1 << Q) + 5) / 10);

    localparam logic signed [N-1:0] K_A   = A;
    localparam logic signed [N-1:0] K_B   = B;
    localparam logic signed [N-1:0] K_D   = D;
    localparam logic signed [N-1:0] K_VTH = V_TH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    // Clamp a double-width signed value into the N-bit range
    function automatic logic signed [N-1:0] f_sat(input logic signed [W2-1:0] x);
        logic signed [N-1:0] r;
        if (x > SMAX) begin
            r = SMAX[N-1:0];
        end else if (x < SMIN) begin
            r = SMIN[N-1:0];
        end else begin
            r = x[N-1:0];
        end
        return r;
    endfunction

    // Full product, floor shift by Q, saturate
    function automatic logic signed [N-1:0] f_mul(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
        logic signed [W2-1:0] p;
        p = W2'(a) * W2'(b);
        return f_sat(p >>> Q);
    endfunction

    function automatic logic signed [N-1:0] f_add(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
        return f_sat(W2'(a) + W2'(b));
    endfunction

    function automatic logic signed [N-1:0] f_sub(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
        return f_sat(W2'(a) - W2'(b));
    endfunction

    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy_nxt;
    logic   w_done_nxt;

    logic [N-1:0]     r_v [NUM_NEURONS];
    logic [N-1:0]     r_w [NUM_NEURONS];
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_step;

    logic signed [N-1:0] r_fv;
    logic signed [N-1:0] r_fw;
    logic signed [N-1:0] r_fi;
    logic signed [N-1:0] r_dv;
    logic signed [N-1:0] r_dw;

    logic         w_last;
    logic [N-1:0] w_v_sel;
    logic [N-1:0] w_w_sel;
    logic [N-1:0] w_i_sel;

    logic signed [N-1:0] w_vv;
    logic signed [N-1:0] w_poly;
    logic signed [N-1:0] w_drive;
    logic signed [N-1:0] w_dv;
    logic signed [N-1:0] w_bvw;
    logic signed [N-1:0] w_dw;
    logic signed [N-1:0] w_v_new;
    logic signed [N-1:0] w_w_new;
    logic signed [N-1:0] w_w_spk;
    logic                w_fire;

    assign w_last = (r_idx == IDX_W'(NUM_NEURONS - 1));

    // Per-neuron operand select (decoded mux keeps reads in range)
    always_comb begin
        w_v_sel = '0;
        w_w_sel = '0;
        w_i_sel = '0;
        for (int k = 0; k < int'(NUM_NEURONS); k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_v_sel = r_v[k];
                w_w_sel = r_w[k];
                w_i_sel = i_flat[k*N +: N];
            end
        end
    end

    // dv = (4v^2 + 5v + 1.4 - w + i) * step, dw = a*(b*v - w) * step
    assign w_vv    = f_mul(r_fv, r_fv);
    assign w_poly  = f_add(f_add(f_mul(K_FOUR, w_vv), f_mul(K_FIVE, r_fv)), K_1P4);
    assign w_drive = f_add(f_sub('0, r_fw), r_fi);
    assign w_dv    = f_mul(f_add(w_poly, w_drive), $signed(r_step));
    assign w_bvw   = f_sub(f_mul(K_B, r_fv), r_fw);
    assign w_dw    = f_mul(f_mul(K_A, w_bvw), $signed(r_step));

    // Integration and threshold on the saturated new potential
    assign w_v_new = f_add(r_fv, r_dv);
    assign w_w_new = f_add(r_fw, r_dw);
    assign w_w_spk = f_add(w_w_new, K_D);
    assign w_fire  = (w_v_new >= K_VTH);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_FETCH;
            S_FETCH:   w_state_nxt = S_COMPUTE;
            S_COMPUTE: w_state_nxt = S_WRITE;
            S_WRITE:   w_state_nxt = w_last ? S_DONE : S_FETCH;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state, then registered
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_FETCH, S_COMPUTE, S_WRITE: w_busy_nxt = 1'b1;
            S_DONE:                      w_done_nxt = 1'b1;
            default:                     ;
        endcase
    end

    // Datapath, neuron state and registered status
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_step <= '0;
            r_fv   <= '0;
            r_fw   <= '0;
            r_fi   <= '0;
            r_dv   <= '0;
            r_dw   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            spikes <= '0;
            for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                r_v[k] <= V_INIT;
                r_w[k] <= W_INIT;
            end
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_step <= step;
                        r_idx  <= '0;
                        spikes <= '0;
                    end
                end
                S_FETCH: begin
                    r_fv <= w_v_sel;
                    r_fw <= w_w_sel;
                    r_fi <= w_i_sel;
                end
                S_COMPUTE: begin
                    r_dv <= w_dv;
                    r_dw <= w_dw;
                end
                S_WRITE: begin
                    if (w_fire) begin
                        r_v[r_idx]    <= C;
                        r_w[r_idx]    <= w_w_spk;
                        spikes[r_idx] <= 1'b1;
                    end else begin
                        r_v[r_idx] <= w_v_new;
                        r_w[r_idx] <= w_w_new;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Readback port; out-of-range selects read zero
    always_comb begin
        v_out = '0;
        w_out = '0;
        for (int k = 0; k < int'(NUM_NEURONS); k++) begin
            if (rd_idx == IDX_W'(k)) begin
                v_out = r_v[k];
                w_out = r_w[k];
            end
        end
    end

endmodule

// File: doc/izhikevich_core_mux.md
Name: izhikevich_core_mux

Overview:
Time-multiplexed, parametrised Izhikevich neuron core. It holds v/w state for NUM_NEURONS neurons and, on each start pulse, performs one forward-Euler timestep for every neuron in sequence on a shared fixed-point datapath. The timestep includes the scaled dv term ((4v²+5v+1.4−w+i)·step), the recovery term dw = a·(b·v−w)·step, threshold detection and after-spike reset. It sits between the input-current source and the spike router, and replaces the single-neuron combinational dv calculator.

Parameters:
N, 16, total word width, signed two's complement
Q, 8, fractional bits
NUM_NEURONS, 4, neurons held/updated per timestep (≥1)
A, 16'h0005, recovery rate a (0.02)
B, 16'h0033, recovery sensitivity b (0.2)
C, 16'hFF5A, after-spike v reset (−0.65)
D, 16'h0014, after-spike w increment (0.08)
V_TH, 16'h004C, spike threshold (0.3)
V_INIT, 16'hFF5A, v value on reset
W_INIT, 16'hFFDF, w value on reset
Localparam IDX_W = max(1, clog2(NUM_NEURONS)).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request one timestep over all neurons; sampled only in IDLE
step  in  N  Euler step; latched when start is accepted
i_flat  in  NUM_NEURONS*N  input currents; neuron k at bits [k*N +: N]; sampled in FETCH of neuron k
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the timestep completes
spikes  out  NUM_NEURONS  bit k = neuron k fired this timestep; valid from done until the next accepted start
rd_idx  in  IDX_W  readback select
v_out  out  N  combinational read of v[rd_idx]
w_out  out  N  combinational read of w[rd_idx]

Behaviour:
- Arithmetic: mult = full 2N-bit signed product, arithmetic shift right by Q (floor), then saturate to [−2^(N−1), 2^(N−1)−1]. add/sub = signed, saturating. Constants 4.0, 5.0 and 1.4 are expressed in Q (1.4 = 16'h0166 at Q=8).
- dv = sat((((4·v·v)+(5·v))+1.4)+((−w)+i))·step. dw = a·(b·v − w)·step. Both terms use the old v and w of the same neuron.
- FSM: IDLE → FETCH → COMPUTE → WRITE → (FETCH with idx+1 | DONE) → IDLE.
  - IDLE: start=1 latches step, clears spikes, sets idx=0 and busy=1.
  - FETCH: registers v[idx], w[idx] and i slice idx.
  - COMPUTE: registers dv and dw.
  - WRITE: v_new = v+dv, w_new = w+dw.
    - If v_new ≥ V_TH (signed): v[idx]←C, w[idx]←sat(w_new+D), spikes[idx]←1.
    - Otherwise: v[idx]←v_new, w[idx]←w_new.
  - DONE: done=1 and busy=0 for exactly this one cycle, then return to IDLE.
- Latency: start accepted at edge T → done high in cycle T+3·NUM_NEURONS+1. Next start can be accepted in the cycle after done.
- start while not in IDLE is ignored; it is not queued.
- step and i_flat may change freely while busy. Only the latched step and the per-neuron FETCH sample are used.
- NUM_NEURONS=1: idx stays 0, and WRITE goes directly to DONE.
- Reset (any state, including mid-timestep) gives:
  - state IDLE, idx=0, busy=0, done=0, spikes=0
  - all v=V_INIT, all w=W_INIT
  - a partially completed timestep is discarded.
- Outputs after reset: busy=0, done=0, spikes=0, v_out=V_INIT, w_out=W_INIT.
- rd_idx ≥ NUM_NEURONS: v_out and w_out read 0.

Test Plan:
- Reset, step=0, i=0, start → done exactly 13 cycles after start edge (NUM_NEURONS=4); all v=0xFF5A, w=0xFFDF, spikes=0.
- Neuron 0 i=0x1000, others i=0, step=0x0100 → neuron 0: v_new=3919 ≥ V_TH, so spikes[0]=1, v=0xFF5A, w=0xFFF2 (dw=−1, then +D); neurons 1–3: no spike.
- Saturation: i=0x7FFF, step=0x7FFF → v path clamps at 0x7FFF before the threshold compare, spike fires, v reset to C; no wrap to negative.
- start pulsed again while busy (mid-neuron 2) → ignored; done occurs once at the original cycle; busy was continuous.
- Reset asserted during COMPUTE of neuron 1 → next cycle busy=0, spikes=0, and v_out for every rd_idx equals 0xFF5A; a fresh start completes normally.
- Back-to-back: start in the cycle after done → accepted; spikes cleared at accept and rebuilt; rd_idx sweep matches the reference model after two timesteps.
